snitch_perf_cnt_unit: RTL and testbench
=======================================

Name: snitch_perf_cnt_unit

Overview:
- Parametrised, source-agnostic performance-counter unit; successor to the fixed-metric cluster counter logic.
- Counts generic multi-bit event increments from NumSources sources (harts, DMA channels, ...) into NumCounters counters of configurable width.
- Adds wrap/saturate mode, overflow and threshold flags with interrupt, global freeze and coherent 64-bit reads via a HI shadow.
- Sits in the cluster peripheral region behind a simple 32-bit register port.

Parameters:
- NumCounters, 16, number of counters (1..32)
- NumSources, 8, event sources (1..256)
- NumEvents, 32, event types per source (1..256)
- IncWidth, 8, width of each per-cycle increment
- CntWidth, 48, counter width (33..64)
- AddrWidth, 10, register-port address width; must cover 0x20*NumCounters+0x4

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- events_i  in  NumSources*NumEvents*IncWidth  per-source, per-event increment, flattened [src][evt]
- req_valid_i  in  1  register access request
- req_write_i  in  1  1 = write
- req_addr_i  in  AddrWidth  byte address, word aligned
- req_wdata_i  in  32  write data
- rsp_valid_o  out  1  response valid, exactly one cycle after req_valid_i
- rsp_rdata_o  out  32  read data, 0 on write or error
- rsp_error_o  out  1  unmapped or misaligned address
- irq_o  out  1  registered OR of enabled, pending flags

Behaviour:
- Reset (rst_i sampled at a clock edge). All of these clear to 0: counters, SEL, CTRL, STATUS, shadow, freeze, event pipeline, rsp_valid_o, rsp_rdata_o, rsp_error_o and irq_o. THR resets to all-ones.
- Reset during a pending access drops that access; no response is issued.
- Event pipeline: events_i is registered once. An event sampled at edge t updates the counter at edge t+1 and is readable by a request issued after edge t+1.
- Address map, counter i at base 0x20*i:
  - +0x00 CNT_LO: bits [31:0].
  - +0x04 CNT_HI: bits [CntWidth-1:32], zero-extended. Reads return the shadow latched by the last CNT_LO read.
  - +0x08 SEL: evt [7:0], src [15:8].
  - +0x0C CTRL: enable [0], saturate [1], ovf_irq_en [2], thr_irq_en [3].
  - +0x10 THR_LO, +0x14 THR_HI.
  - +0x18 STATUS: ovf [0], thr [1]; write-1-to-clear.
- Global register at 0x20*NumCounters, GCTRL:
  - freeze [0]: read/write.
  - clear_all [1]: write-only strobe, reads 0.
- Any other address sets rsp_error_o=1; the write is ignored.
- Increment per cycle: inc = piped event[src][evt], applied when enable=1 and freeze=0. If src >= NumSources or evt >= NumEvents, inc = 0.
- Arithmetic: sum = cnt + zero-extended inc, computed CntWidth+1 wide.
  - carry = 1: set ovf. Wrap mode loads sum[CntWidth-1:0]; saturate mode holds all-ones.
  - Threshold flag sets when cnt_q < thr_q and new value >= thr_q.
- Priority per counter, highest first: reset > clear_all > software write to CNT_LO/CNT_HI > increment.
  - A write replaces only the addressed half; the increment for that cycle is dropped.
  - Writes never set flags.
  - clear_all zeroes all counters and STATUS; it does not change SEL or CTRL.
- If a STATUS W1C and a flag set occur in the same cycle, the set wins.
- Read data is the register state before the request's edge. The shadow is updated at the same edge the CNT_LO read is sampled.
- irq_o is registered and becomes 1 one cycle after any (ovf & ovf_irq_en) | (thr & thr_irq_en) is true.
- One request is accepted per cycle. Back-to-back requests produce back-to-back responses.

Test Plan:
- Reset, then read CTRL0, CNT_LO0 and THR_HI0 → 0, 0, 0xFFFF (bits [47:32] of the all-ones THR, for CntWidth=48). irq_o=0 and rsp_valid_o=0 during reset.
- SEL0 = src 2 / evt 5, enable=1; drive increment 3 for 10 cycles → CNT_LO0 = 30. Same setup with src 9 (>= NumSources) → CNT_LO0 = 0.
- Write CNT_LO/HI to 0xFFFF_FFFF_FFFE (CntWidth=48), increment 4:
  - wrap mode → 0x2, ovf=1.
  - saturate mode → 0xFFFF_FFFF_FFFF, ovf=1.
  - With ovf_irq_en=1, irq_o rises one cycle after the flag; W1C STATUS clears irq_o the cycle after.
- THR=100, count by 7 from 0 → thr sets at the edge the counter becomes 105 (not at 98). A simultaneous W1C on that cycle leaves thr=1.
- Counter at 0x0000_FFFF_FFFF incrementing by 1:
  - Read CNT_LO (returns 0xFFFF_FFFF), then CNT_HI two cycles later → 0x0000 (the shadow), although the live HI is already 1.
- Set freeze=1 while events stream → count is unchanged; freeze=0 resumes counting. Write clear_all in the same cycle as a CNT_LO write → counter = 0. Access to address 0x3FC → rsp_error_o=1, rdata 0.

Source files
------------

// File: rtl/snitch_perf_cnt_unit.sv
// snitch_perf_cnt_unit: generic multi-source performance counters with
// wrap/saturate, overflow/threshold interrupts, freeze and a coherent HI shadow.
module snitch_perf_cnt_unit #(
    parameter int unsigned NumCounters = 16,
    parameter int unsigned NumSources  = 8,
    parameter int unsigned NumEvents   = 32,
    parameter int unsigned IncWidth    = 8,
    parameter int unsigned CntWidth    = 48,
    parameter int unsigned AddrWidth   = 10
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic [NumSources*NumEvents*IncWidth-1:0] events_i,
    input  logic                                   req_valid_i,
    input  logic                                   req_write_i,
    input  logic [AddrWidth-1:0]                   req_addr_i,
    input  logic [31:0]                            req_wdata_i,
    output logic                                   rsp_valid_o,
    output logic [31:0]                            rsp_rdata_o,
    output logic                                   rsp_error_o,
    output logic                                   irq_o
);

    localparam int unsigned HiW  = CntWidth - 32;
    localparam int unsigned SrcW = (NumSources > 1) ? $clog2(NumSources) : 1;
    localparam int unsigned EvtW = (NumEvents > 1) ? $clog2(NumEvents) : 1;
    localparam int unsigned IdxW = AddrWidth - 5;
    localparam logic [AddrWidth-1:0] GAddr = AddrWidth'(32 * NumCounters);

    logic [NumSources-1:0][NumEvents-1:0][IncWidth-1:0] ev_q;

    logic [CntWidth-1:0] cnt_q    [NumCounters];
    logic [CntWidth-1:0] cnt_d    [NumCounters];
    logic [15:0]         sel_q    [NumCounters];
    logic [15:0]         sel_d    [NumCounters];
    logic [3:0]          ctrl_q   [NumCounters];
    logic [3:0]          ctrl_d   [NumCounters];
    logic [CntWidth-1:0] thr_q    [NumCounters];
    logic [CntWidth-1:0] thr_d    [NumCounters];
    logic [1:0]          status_q [NumCounters];
    logic [1:0]          status_d [NumCounters];

    logic [IncWidth-1:0] inc     [NumCounters];
    logic [CntWidth:0]   sum     [NumCounters];
    logic [CntWidth-1:0] cnt_inc [NumCounters];
    logic [1:0]          fset    [NumCounters];

    logic [HiW-1:0] shadow_q, shadow_d;
    logic           freeze_q, freeze_d;
    logic           rsp_valid_q, rsp_error_q, irq_q, irq_d;
    logic [31:0]    rsp_rdata_q, rdata;

    logic [IdxW-1:0]        a_idx;
    logic [2:0]             a_off;
    logic                   aligned, in_range, hit_cnt, hit_g, acc_err;
    logic                   wr_en, rd_en, clear_all, run;
    logic [NumCounters-1:0] wr_sel, rd_sel;

    assign a_idx     = req_addr_i[AddrWidth-1:5];
    assign a_off     = req_addr_i[4:2];
    assign aligned   = (req_addr_i[1:0] == 2'b00);
    assign in_range  = (32'(a_idx) < NumCounters);
    assign hit_cnt   = aligned & in_range & (a_off != 3'd7);
    assign hit_g     = (req_addr_i == GAddr);
    assign acc_err   = ~(hit_cnt | hit_g);
    assign wr_en     = req_valid_i & req_write_i & ~acc_err;
    assign rd_en     = req_valid_i & ~req_write_i & ~acc_err;
    assign clear_all = wr_en & hit_g & req_wdata_i[1];
    assign run       = ~freeze_q;

    always_comb begin
        wr_sel = '0;
        rd_sel = '0;
        for (int i = 0; i < NumCounters; i++) begin
            wr_sel[i] = wr_en & hit_cnt & (32'(a_idx) == 32'(i));
            rd_sel[i] = rd_en & hit_cnt & (32'(a_idx) == 32'(i));
        end
    end

    // Out-of-range source/event selections contribute nothing.
    always_comb begin
        for (int i = 0; i < NumCounters; i++) begin
            inc[i] = '0;
            if (({1'b0, sel_q[i][15:8]} < 9'(NumSources)) &&
                ({1'b0, sel_q[i][7:0]} < 9'(NumEvents))) begin
                inc[i] = ev_q[sel_q[i][8 +: SrcW]][sel_q[i][0 +: EvtW]];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NumCounters; i++) begin
            sum[i]     = {1'b0, cnt_q[i]} + (CntWidth+1)'(inc[i]);
            cnt_inc[i] = sum[i][CntWidth-1:0];
            if (sum[i][CntWidth] && ctrl_q[i][1]) begin
                cnt_inc[i] = '1;
            end
            fset[i] = '0;
            if (ctrl_q[i][0] && run) begin
                fset[i][0] = sum[i][CntWidth];
                fset[i][1] = (cnt_q[i] < thr_q[i]) && (cnt_inc[i] >= thr_q[i]);
            end
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        ctrl_d   = ctrl_q;
        thr_d    = thr_q;
        status_d = status_q;
        for (int i = 0; i < NumCounters; i++) begin
            if (clear_all) begin
                cnt_d[i]    = '0;
                status_d[i] = '0;
            end else begin
                if (wr_sel[i] && (a_off == 3'd6)) begin
                    status_d[i] = status_q[i] & ~req_wdata_i[1:0];
                end
                // A software write to either half drops this cycle's increment.
                if (wr_sel[i] && (a_off == 3'd0)) begin
                    cnt_d[i][31:0] = req_wdata_i;
                end else if (wr_sel[i] && (a_off == 3'd1)) begin
                    cnt_d[i][CntWidth-1:32] = req_wdata_i[HiW-1:0];
                end else if (ctrl_q[i][0] && run) begin
                    cnt_d[i]    = cnt_inc[i];
                    status_d[i] = status_d[i] | fset[i];
                end
            end
            if (wr_sel[i]) begin
                case (a_off)
                    3'd2:    sel_d[i]  = req_wdata_i[15:0];
                    3'd3:    ctrl_d[i] = req_wdata_i[3:0];
                    3'd4:    thr_d[i][31:0] = req_wdata_i;
                    3'd5:    thr_d[i][CntWidth-1:32] = req_wdata_i[HiW-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        freeze_d = freeze_q;
        if (wr_en && hit_g) begin
            freeze_d = req_wdata_i[0];
        end
    end

    // The shadow captures HI together with the LO read for coherent 64-bit reads.
    always_comb begin
        rdata    = '0;
        shadow_d = shadow_q;
        if (rd_en && hit_g) begin
            rdata = {31'b0, freeze_q};
        end
        for (int i = 0; i < NumCounters; i++) begin
            if (rd_sel[i]) begin
                case (a_off)
                    3'd0: begin
                        rdata    = cnt_q[i][31:0];
                        shadow_d = cnt_q[i][CntWidth-1:32];
                    end
                    3'd1:    rdata = 32'(shadow_q);
                    3'd2:    rdata = 32'(sel_q[i]);
                    3'd3:    rdata = 32'(ctrl_q[i]);
                    3'd4:    rdata = thr_q[i][31:0];
                    3'd5:    rdata = 32'(thr_q[i][CntWidth-1:32]);
                    3'd6:    rdata = 32'(status_q[i]);
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        irq_d = 1'b0;
        for (int i = 0; i < NumCounters; i++) begin
            irq_d = irq_d | (status_q[i][0] & ctrl_q[i][2])
                          | (status_q[i][1] & ctrl_q[i][3]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ev_q        <= '0;
            shadow_q    <= '0;
            freeze_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
            irq_q       <= 1'b0;
            for (int i = 0; i < NumCounters; i++) begin
                cnt_q[i]    <= '0;
                sel_q[i]    <= '0;
                ctrl_q[i]   <= '0;
                thr_q[i]    <= '1;
                status_q[i] <= '0;
            end
        end else begin
            ev_q        <= events_i;
            shadow_q    <= shadow_d;
            freeze_q    <= freeze_d;
            rsp_valid_q <= req_valid_i;
            rsp_rdata_q <= rdata;
            rsp_error_q <= req_valid_i & acc_err;
            irq_q       <= irq_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            ctrl_q      <= ctrl_d;
            thr_q       <= thr_d;
            status_q    <= status_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_error_o = rsp_error_q;
    assign irq_o       = irq_q;

endmodule

// File: tb/tb_snitch_perf_cnt_unit.sv
// tb_snitch_perf_cnt_unit: register-table vectors, directed corner sequences
// and randomized event streams against a behavioural counter model.
module tb_snitch_perf_cnt_unit;

    typedef logic [7:0][31:0][7:0] ev_t;

    typedef struct {
        bit          w;
        logic [9:0]  a;
        logic [31:0] d;
        logic [31:0] rd;
        bit          err;
        string       nm;
    } vec_t;

    localparam longint unsigned MAX = 64'h0000_FFFF_FFFF_FFFF;
    localparam logic [9:0] GCTRL = 10'h200;

    logic        clk = 1'b0;
    logic        rst;
    ev_t         ev;
    logic        req_valid, req_write;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_error, irq;
    logic [31:0] rsp_rdata;

    int n_checks = 0;
    int n_err    = 0;

    vec_t tbl[21];

    longint unsigned m_cnt[4], m_thr[4];
    bit              m_ovf[4], m_thf[4], m_en[4], m_sat[4];
    int              m_src[4], m_evt[4];

    snitch_perf_cnt_unit dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .events_i    (ev),
        .req_valid_i (req_valid),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_error_o (rsp_error),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    function automatic logic [9:0] A(input int c, input int off);
        return 10'(32 * c + off);
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    // Called on a falling edge; returns on the next falling edge with the response.
    task automatic access(input bit w, input logic [9:0] a, input logic [31:0] d,
                          output logic [31:0] r, output logic e, output logic v);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'b0;
        r = rsp_rdata;
        e = rsp_error;
        v = rsp_valid;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        logic [31:0] r;
        logic e, v;
        access(1'b1, a, d, r, e, v);
    endtask

    task automatic rd_chk(input string nm, input logic [9:0] a, input logic [31:0] exp);
        logic [31:0] r;
        logic e, v;
        access(1'b0, a, 32'h0, r, e, v);
        chk(nm, r, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cnt(input int c, input logic [47:0] val);
        wr(A(c, 0), val[31:0]);
        wr(A(c, 4), 32'(val[47:32]));
    endtask

    function automatic void model_step(input ev_t e);
        longint unsigned inc, s, nv;
        for (int c = 0; c < 4; c++) begin
            if (m_en[c]) begin
                inc = 0;
                if (m_src[c] < 8 && m_evt[c] < 32) inc = e[m_src[c]][m_evt[c]];
                s = m_cnt[c] + inc;
                if (s > MAX) begin
                    m_ovf[c] = 1'b1;
                    nv = m_sat[c] ? MAX : s - (MAX + 1);
                end else begin
                    nv = s;
                end
                if (m_cnt[c] < m_thr[c] && nv >= m_thr[c]) m_thf[c] = 1'b1;
                m_cnt[c] = nv;
            end
        end
    endfunction

    initial begin
        logic [31:0] r;
        logic e, v;
        ev_t prev;

        tbl[0]  = '{1'b0, 10'h00C, 32'h0,         32'h0,         1'b0, "ctrl0_rst"};
        tbl[1]  = '{1'b0, 10'h000, 32'h0,         32'h0,         1'b0, "cntlo0_rst"};
        tbl[2]  = '{1'b0, 10'h014, 32'h0,         32'h0000_FFFF, 1'b0, "thrhi0_rst"};
        tbl[3]  = '{1'b0, 10'h010, 32'h0,         32'hFFFF_FFFF, 1'b0, "thrlo0_rst"};
        tbl[4]  = '{1'b0, 10'h008, 32'h0,         32'h0,         1'b0, "sel0_rst"};
        tbl[5]  = '{1'b0, 10'h018, 32'h0,         32'h0,         1'b0, "status0_rst"};
        tbl[6]  = '{1'b0, GCTRL,   32'h0,         32'h0,         1'b0, "gctrl_rst"};
        tbl[7]  = '{1'b1, 10'h0A8, 32'hABCD_1234, 32'h0,         1'b0, "sel5_wr"};
        tbl[8]  = '{1'b0, 10'h0A8, 32'h0,         32'h0000_1234, 1'b0, "sel5_rd"};
        tbl[9]  = '{1'b1, 10'h0AC, 32'hFFFF_FFFF, 32'h0,         1'b0, "ctrl5_wr"};
        tbl[10] = '{1'b0, 10'h0AC, 32'h0,         32'h0000_000F, 1'b0, "ctrl5_rd"};
        tbl[11] = '{1'b1, 10'h0AC, 32'h0,         32'h0,         1'b0, "ctrl5_clr"};
        tbl[12] = '{1'b0, 10'h3FC, 32'h0,         32'h0,         1'b1, "unmapped_rd"};
        tbl[13] = '{1'b0, 10'h0BC, 32'h0,         32'h0,         1'b1, "hole_rd"};
        tbl[14] = '{1'b0, 10'h202, 32'h0,         32'h0,         1'b1, "misalign_rd"};
        tbl[15] = '{1'b1, 10'h3FC, 32'hFFFF_FFFF, 32'h0,         1'b1, "unmapped_wr"};
        tbl[16] = '{1'b1, GCTRL,   32'h3,         32'h0,         1'b0, "gctrl_wr"};
        tbl[17] = '{1'b0, GCTRL,   32'h0,         32'h1,         1'b0, "gctrl_rd"};
        tbl[18] = '{1'b1, GCTRL,   32'h0,         32'h0,         1'b0, "gctrl_unfrz"};
        tbl[19] = '{1'b0, 10'h204, 32'h0,         32'h0,         1'b1, "past_gctrl"};
        tbl[20] = '{1'b0, 10'h1F4, 32'h0,         32'h0000_FFFF, 1'b0, "thrhi15_rst"};

        rst       = 1'b1;
        ev        = '0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 10'h0;
        req_wdata = 32'h0;
        step(3);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_irq", irq, 1'b0);
        rst       = 1'b0;
        req_valid = 1'b0;
        step(1);

        for (int k = 0; k < 21; k++) begin
            access(tbl[k].w, tbl[k].a, tbl[k].d, r, e, v);
            chk({tbl[k].nm, "_rdata"}, r, tbl[k].rd);
            chk({tbl[k].nm, "_err"}, e, tbl[k].err);
            chk({tbl[k].nm, "_valid"}, v, 1'b1);
        end

        wr(A(0, 8), 32'h0205);
        wr(A(0, 12), 32'h1);
        ev[2][5] = 8'd3;
        step(10);
        ev = '0;
        step(2);
        rd_chk("count_30", A(0, 0), 32'd30);

        wr(A(0, 8), 32'h0905);
        set_cnt(0, 48'h0);
        for (int s = 0; s < 8; s++)
            for (int q = 0; q < 32; q++) ev[s][q] = 8'd3;
        step(10);
        ev = '0;
        step(2);
        rd_chk("src_oor", A(0, 0), 32'd0);

        wr(A(0, 8), 32'h0205);
        wr(A(0, 12), 32'h1);
        set_cnt(0, 48'hFFFF_FFFF_FFFE);
        wr(A(0, 24), 32'h3);
        ev[2][5] = 8'd4;
        step(1);
        ev = '0;
        step(2);
        rd_chk("wrap_lo", A(0, 0), 32'h2);
        rd_chk("wrap_hi", A(0, 4), 32'h0);
        rd_chk("wrap_status", A(0, 24), 32'h1);

        wr(A(0, 12), 32'h3);
        set_cnt(0, 48'hFFFF_FFFF_FFFE);
        wr(A(0, 24), 32'h3);
        ev[2][5] = 8'd4;
        step(1);
        ev = '0;
        step(2);
        rd_chk("sat_lo", A(0, 0), 32'hFFFF_FFFF);
        rd_chk("sat_hi", A(0, 4), 32'h0000_FFFF);
        rd_chk("sat_status", A(0, 24), 32'h3);

        wr(A(0, 12), 32'h5);
        set_cnt(0, 48'hFFFF_FFFF_FFFE);
        wr(A(0, 24), 32'h3);
        step(1);
        chk("irq_idle", irq, 1'b0);
        ev[2][5] = 8'd4;
        step(1);
        ev = '0;
        step(1);
        chk("irq_same_cycle", irq, 1'b0);
        step(1);
        chk("irq_rise", irq, 1'b1);
        wr(A(0, 24), 32'h1);
        chk("irq_hold", irq, 1'b1);
        step(1);
        chk("irq_clear", irq, 1'b0);

        wr(A(0, 12), 32'h1);
        wr(A(0, 16), 32'd100);
        wr(A(0, 20), 32'h0);
        set_cnt(0, 48'h0);
        wr(A(0, 24), 32'h3);
        ev[2][5] = 8'd7;
        step(14);
        ev = '0;
        step(2);
        rd_chk("thr_98_cnt", A(0, 0), 32'd98);
        rd_chk("thr_98_status", A(0, 24), 32'h0);
        ev[2][5] = 8'd7;
        step(1);
        ev = '0;
        step(2);
        rd_chk("thr_105_cnt", A(0, 0), 32'd105);
        rd_chk("thr_105_status", A(0, 24), 32'h2);
        set_cnt(0, 48'd98);
        wr(A(0, 24), 32'h3);
        ev[2][5] = 8'd7;
        step(1);
        ev = '0;
        wr(A(0, 24), 32'h2);
        step(1);
        rd_chk("thr_w1c_race", A(0, 24), 32'h2);

        wr(A(0, 16), 32'hFFFF_FFFF);
        wr(A(0, 20), 32'h0000_FFFF);
        set_cnt(0, 48'h0000_FFFF_FFFF);
        ev[2][5] = 8'd1;
        rd_chk("shadow_lo", A(0, 0), 32'hFFFF_FFFF);
        step(1);
        rd_chk("shadow_hi", A(0, 4), 32'h0);
        ev = '0;
        step(2);
        rd_chk("live_lo", A(0, 0), 32'h2);
        rd_chk("live_hi", A(0, 4), 32'h1);

        set_cnt(0, 48'h0);
        wr(GCTRL, 32'h1);
        ev[2][5] = 8'd5;
        step(10);
        ev = '0;
        step(2);
        rd_chk("frozen_cnt", A(0, 0), 32'd0);
        rd_chk("frozen_gctrl", GCTRL, 32'h1);
        wr(GCTRL, 32'h0);
        ev[2][5] = 8'd5;
        step(4);
        ev = '0;
        step(2);
        rd_chk("thawed_cnt", A(0, 0), 32'd20);

        wr(A(0, 0), 32'h1234);
        wr(GCTRL, 32'h2);
        rd_chk("clr_cnt", A(0, 0), 32'h0);
        rd_chk("clr_status", A(0, 24), 32'h0);
        rd_chk("clr_keeps_ctrl", A(0, 12), 32'h1);
        rd_chk("clr_keeps_sel", A(0, 8), 32'h0205);
        rd_chk("clr_gctrl", GCTRL, 32'h0);

        for (int rnd = 0; rnd < 6; rnd++) begin
            wr(GCTRL, 32'h2);
            for (int c = 0; c < 4; c++) begin
                m_src[c] = $urandom_range(0, 9);
                m_evt[c] = $urandom_range(0, 33);
                m_en[c]  = ($urandom_range(0, 3) != 0);
                m_sat[c] = $urandom_range(0, 1);
                m_ovf[c] = 1'b0;
                m_thf[c] = 1'b0;
                if ($urandom_range(0, 1) == 1) m_cnt[c] = MAX - $urandom_range(0, 3000);
                else m_cnt[c] = $urandom_range(0, 1000);
                case ($urandom_range(0, 2))
                    0: begin
                        m_thr[c] = m_cnt[c] + $urandom_range(0, 6000);
                        if (m_thr[c] > MAX) m_thr[c] = MAX;
                    end
                    1: m_thr[c] = {$urandom, $urandom} & MAX;
                    default: m_thr[c] = $urandom_range(0, 5000);
                endcase
                wr(A(c, 8), {16'h0, 8'(m_src[c]), 8'(m_evt[c])});
                wr(A(c, 12), {30'h0, m_sat[c], m_en[c]});
                set_cnt(c, m_cnt[c][47:0]);
                wr(A(c, 16), m_thr[c][31:0]);
                wr(A(c, 20), {16'h0, m_thr[c][47:32]});
            end
            prev = '0;
            for (int k = 0; k <= 40; k++) begin
                if (k > 0) model_step(prev);
                if (k < 40) begin
                    for (int s = 0; s < 8; s++)
                        for (int q = 0; q < 32; q++) ev[s][q] = 8'($urandom);
                end else begin
                    ev = '0;
                end
                prev = ev;
                @(negedge clk);
            end
            step(2);
            for (int c = 0; c < 4; c++) begin
                rd_chk($sformatf("rnd%0d_c%0d_lo", rnd, c), A(c, 0), m_cnt[c][31:0]);
                rd_chk($sformatf("rnd%0d_c%0d_hi", rnd, c), A(c, 4), {16'h0, m_cnt[c][47:32]});
                rd_chk($sformatf("rnd%0d_c%0d_status", rnd, c), A(c, 24), {30'h0, m_thf[c], m_ovf[c]});
            end
        end

        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = A(0, 12);
        rst       = 1'b1;
        @(negedge clk);
        chk("rst_drop_valid", rsp_valid, 1'b0);
        chk("rst_drop_irq", irq, 1'b0);
        rst       = 1'b0;
        req_valid = 1'b0;
        step(1);
        rd_chk("post_rst_ctrl", A(0, 12), 32'h0);
        rd_chk("post_rst_thrlo", A(0, 16), 32'hFFFF_FFFF);
        rd_chk("post_rst_cnt", A(1, 0), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
